// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM generator.
// Optional build macro used elsewhere: PWM_CENTER_ALIGNED_EN.
package pwm_pkg;

  localparam int PERIOD_MIN = 2;

  typedef logic [2:0] deb_hist_t;

  localparam deb_hist_t HIST_PRESS = 3'b011;

  function automatic int clamp_period(input int p);
    return (p < PERIOD_MIN) ? PERIOD_MIN : p;
  endfunction

endpackage

// File: rtl/pwm_debounce.sv
// Button debouncer: two-flop synchronizer, divided sample tick, one pulse per press.
// A press is a low sample followed by two high samples; holding gives one pulse only.
module pwm_debounce
  import pwm_pkg::*;
#(
  parameter int DEB_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int DIV_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       sync_q, sync_d;
  deb_hist_t        hist_q, hist_d;
  logic             press_q, press_d;
  logic             tick;

  always_comb begin
    tick    = (div_q == '0);
    div_d   = tick ? DIV_W'(DEB_DIV - 1) : div_q - 1'b1;
    sync_d  = {sync_q[0], btn_i};
    hist_d  = hist_q;
    press_d = 1'b0;
    if (tick) begin
      hist_d  = {hist_q[1:0], sync_q[1]};
      press_d = (hist_d == HIST_PRESS);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q   <= '0;
      sync_q  <= '0;
      hist_q  <= '0;
      press_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/pwm_generator_multi.sv
// Multi-channel PWM with shared period counter and button-stepped, double-buffered duties.
// Define PWM_CENTER_ALIGNED_EN for an up/down (center-aligned) counter.
module pwm_generator_multi
  import pwm_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int CNT_W        = 8,
  parameter int PERIOD_RESET = 10,
  parameter int DUTY_RESET   = 5,
  parameter int DUTY_STEP    = 1,
  parameter int DEB_DIV      = 4,
  localparam int SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                increase_duty,
  input  logic                decrease_duty,
  input  logic [SEL_W-1:0]    ch_sel,
  input  logic [CNT_W-1:0]    period_cfg,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                cycle_start,
  output logic [CNT_W-1:0]    duty_sel
);

  localparam logic [CNT_W-1:0] STEP_N = CNT_W'(DUTY_STEP);
  localparam logic [CNT_W:0]   STEP_X = (CNT_W + 1)'(DUTY_STEP);

  logic                inc_press, dec_press;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    period_act_q, period_act_d;
  logic [CNT_W-1:0]    duty_shadow_q [CHANNELS];
  logic [CNT_W-1:0]    duty_shadow_d [CHANNELS];
  logic [CNT_W-1:0]    duty_act_q [CHANNELS];
  logic [CNT_W-1:0]    duty_act_d [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                cycle_start_q;
  logic [CNT_W-1:0]    duty_sel_q, duty_sel_d;
  logic                load;
  logic [CNT_W-1:0]    sel_shadow, inc_val, dec_val;
  logic [CNT_W:0]      inc_sum;
`ifdef PWM_CENTER_ALIGNED_EN
  logic                dir_up_q, dir_up_d;
`endif

  pwm_debounce #(.DEB_DIV(DEB_DIV)) u_deb_inc (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (increase_duty),
    .press_o (inc_press)
  );

  pwm_debounce #(.DEB_DIV(DEB_DIV)) u_deb_dec (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (decrease_duty),
    .press_o (dec_press)
  );

`ifdef PWM_CENTER_ALIGNED_EN
  // Bottom of the triangle (next cnt is 0) is the only reload point.
  always_comb begin
    dir_up_d = dir_up_q;
    if (dir_up_q) begin
      if (cnt_q >= period_act_q - 1'b1) begin
        cnt_d    = period_act_q - CNT_W'(2);
        dir_up_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
    load = (cnt_d == '0);
    if (load) dir_up_d = 1'b1;
  end
`else
  always_comb begin
    load  = (cnt_q >= period_act_q - 1'b1);
    cnt_d = load ? '0 : cnt_q + 1'b1;
  end
`endif

  always_comb begin
    period_act_d = load ? CNT_W'(clamp_period(int'(period_cfg))) : period_act_q;

    sel_shadow = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_sel == SEL_W'(i)) sel_shadow = duty_shadow_q[i];
    end
    duty_sel_d = sel_shadow;

    // Saturate against the running period, computed one bit wider so it cannot wrap.
    inc_sum = {1'b0, sel_shadow} + STEP_X;
    inc_val = (inc_sum > {1'b0, period_act_q}) ? period_act_q : inc_sum[CNT_W-1:0];
    dec_val = (sel_shadow < STEP_N) ? '0 : sel_shadow - STEP_N;

    for (int i = 0; i < CHANNELS; i++) begin
      duty_shadow_d[i] = duty_shadow_q[i];
      if (ch_sel == SEL_W'(i)) begin
        if (inc_press && !dec_press)      duty_shadow_d[i] = inc_val;
        else if (dec_press && !inc_press) duty_shadow_d[i] = dec_val;
      end
      duty_act_d[i] = load ? duty_shadow_q[i] : duty_act_q[i];
      pwm_d[i]      = (cnt_q < duty_act_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      period_act_q  <= CNT_W'(PERIOD_RESET);
      pwm_q         <= '0;
      cycle_start_q <= 1'b0;
      duty_sel_q    <= CNT_W'(DUTY_RESET);
      for (int i = 0; i < CHANNELS; i++) begin
        duty_shadow_q[i] <= CNT_W'(DUTY_RESET);
        duty_act_q[i]    <= CNT_W'(DUTY_RESET);
      end
    end else begin
      cnt_q         <= cnt_d;
      period_act_q  <= period_act_d;
      pwm_q         <= pwm_d;
      cycle_start_q <= (cnt_q == '0);
      duty_sel_q    <= duty_sel_d;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_shadow_q[i] <= duty_shadow_d[i];
        duty_act_q[i]    <= duty_act_d[i];
      end
    end
  end

`ifdef PWM_CENTER_ALIGNED_EN
  always_ff @(posedge clk) begin
    if (!rst_n) dir_up_q <= 1'b1;
    else        dir_up_q <= dir_up_d;
  end
`endif

  assign pwm_out     = pwm_q;
  assign cycle_start = cycle_start_q;
  assign duty_sel    = duty_sel_q;

endmodule
